io_uart_tx: RTL



---
 rtl/io_uart_tx.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter on the CPU I/O bus.
// DATA/STATUS register at BASE_ADDR, CTRL register at BASE_ADDR+1.
// Written bytes are queued in a small circular FIFO and sent LSB first.
// Optional build macro IO_UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit (11-bit frames instead of 10).
module io_uart_tx #(
    parameter logic [7:0] BASE_ADDR    = 8'h10,
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic [7:0] i_bus,
    output logic [7:0] o_bus,
    input  logic       i_ioSelect,
    input  logic [7:0] i_ioAddress,
    input  logic       i_ioNOE,
    input  logic       i_ioNWE,
    output logic       o_txd
);

    localparam int PTR_W  = (FIFO_DEPTH == 4) ? 2 : 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [7:0]        CTRL_ADDR = BASE_ADDR + 8'd1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [2:0]        CNT_FULL  = 3'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

`ifdef IO_UART_TX_PARITY_EN
    // Even parity: the parity bit makes the total number of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

    // Bus decode
    logic       sel_data_s;
    logic       sel_ctrl_s;
    logic       wr_data_s;
    logic       wr_ctrl_s;
    logic       rd_en_s;
    logic [7:0] rd_data_s;

    // FIFO
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [2:0]       count_r;
    logic             empty_s;
    logic             full_s;
    logic             push_ok_s;
    logic [7:0]       head_s;

    // Control / status
    logic overflow_r;
    logic enable_r;
    logic busy_s;

    // Transmit FSM and datapath
    state_t            state_r, state_next;
    logic [BAUD_W-1:0] baud_r, baud_next;
    logic [2:0]        bit_r, bit_next;
    logic [7:0]        shift_r, shift_next;
    logic              txd_r, txd_next;
    logic              pop_s;
    logic              baud_last_s;
`ifdef IO_UART_TX_PARITY_EN
    logic              parity_r, parity_next;
`endif

    assign sel_data_s = i_ioSelect && (i_ioAddress == BASE_ADDR);
    assign sel_ctrl_s = i_ioSelect && (i_ioAddress == CTRL_ADDR);
    assign wr_data_s  = sel_data_s && !i_ioNWE;
    assign wr_ctrl_s  = sel_ctrl_s && !i_ioNWE;
    assign rd_en_s    = (sel_data_s || sel_ctrl_s) && !i_ioNOE;

    assign empty_s     = (count_r == 3'd0);
    assign full_s      = (count_r == CNT_FULL);
    assign busy_s      = (state_r != S_IDLE);
    assign head_s      = mem_r[rd_ptr_r];
    assign baud_last_s = (baud_r == BAUD_LAST);

    // A push while full is still accepted when the FSM pops on the same edge.
    assign push_ok_s = wr_data_s && (!full_s || pop_s);

    // Read mux: STATUS or CTRL, selected by the decoded address.
    always_comb begin
        rd_data_s = 8'h00;
        if (sel_ctrl_s) begin
            rd_data_s = {7'b0000000, enable_r};
        end else begin
            rd_data_s = {1'b0, count_r, overflow_r, busy_s, empty_s, full_s};
        end
    end

    // The bus is released whenever no decoded read is in progress.
    assign o_bus = rd_en_s ? rd_data_s : 8'hzz;
    assign o_txd = txd_r;

    // FIFO storage, pointers and fill level.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 3'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= i_bus;
                wr_ptr_r        <= (wr_ptr_r == PTR_LAST) ? '0 : wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? '0 : rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Enable bit and sticky overflow flag.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            enable_r   <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (wr_ctrl_s) begin
                enable_r <= i_bus[0];
            end
            if (wr_data_s && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end else if (wr_ctrl_s && i_bus[1]) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Transmit FSM state and datapath registers; txd is registered here.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_r  <= S_IDLE;
            baud_r   <= '0;
            bit_r    <= 3'd0;
            shift_r  <= 8'h00;
            txd_r    <= 1'b1;
`ifdef IO_UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_next;
            baud_r   <= baud_next;
            bit_r    <= bit_next;
            shift_r  <= shift_next;
            txd_r    <= txd_next;
`ifdef IO_UART_TX_PARITY_EN
            parity_r <= parity_next;
`endif
        end
    end

    // Next-state logic; txd_next is the line level for the upcoming cycle.
    always_comb begin
        state_next  = state_r;
        baud_next   = baud_r;
        bit_next    = bit_r;
        shift_next  = shift_r;
        txd_next    = txd_r;
        pop_s       = 1'b0;
`ifdef IO_UART_TX_PARITY_EN
        parity_next = parity_r;
`endif
        case (state_r)
            S_IDLE: begin
                baud_next = '0;
                bit_next  = 3'd0;
                if (enable_r && !empty_s) begin
                    pop_s       = 1'b1;
                    shift_next  = head_s;
`ifdef IO_UART_TX_PARITY_EN
                    parity_next = even_parity(head_s);
`endif
                    state_next  = S_START;
                    txd_next    = 1'b0;
                end else begin
                    txd_next = 1'b1;
                end
            end
            S_START: begin
                if (baud_last_s) begin
                    baud_next  = '0;
                    state_next = S_DATA;
                    txd_next   = shift_r[0];
                end else begin
                    baud_next = baud_r + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_last_s) begin
                    baud_next = '0;
                    if (bit_r == 3'd7) begin
                        bit_next   = 3'd0;
`ifdef IO_UART_TX_PARITY_EN
                        state_next = S_PARITY;
                        txd_next   = parity_r;
`else
                        state_next = S_STOP;
                        txd_next   = 1'b1;
`endif
                    end else begin
                        bit_next   = bit_r + 3'd1;
                        shift_next = {1'b0, shift_r[7:1]};
                        txd_next   = shift_r[1];
                    end
                end else begin
                    baud_next = baud_r + BAUD_W'(1);
                end
            end
`ifdef IO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_last_s) begin
                    baud_next  = '0;
                    state_next = S_STOP;
                    txd_next   = 1'b1;
                end else begin
                    baud_next = baud_r + BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_last_s) begin
                    baud_next = '0;
                    if (enable_r && !empty_s) begin
                        // Chain straight into the next frame with no idle bit.
                        pop_s       = 1'b1;
                        shift_next  = head_s;
`ifdef IO_UART_TX_PARITY_EN
                        parity_next = even_parity(head_s);
`endif
                        state_next  = S_START;
                        txd_next    = 1'b0;
                    end else begin
                        state_next = S_IDLE;
                        txd_next   = 1'b1;
                    end
                end else begin
                    baud_next = baud_r + BAUD_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                baud_next  = '0;
                bit_next   = 3'd0;
                txd_next   = 1'b1;
            end
        endcase
    end

endmodule
